config_uart_v2: RTL and testbench

CONFIG_UART_V2 -- requirements
Module: config_uart_v2

---
 rtl/config_uart_pkg.sv | 46 ++++
 rtl/config_uart_v2_if.sv | 20 ++
 rtl/uart_rx_core.sv | 119 +++++++++++
 rtl/config_uart_v2.sv | 192 +++++++++++++++++++
 tb/tb_config_uart_v2.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/config_uart_pkg.sv
// Shared types for the configuration UART: receiver and protocol state enums,
// data-mode encodings and the ASCII-to-hex decoder.
package config_uart_pkg;

  localparam int unsigned CHECKSUM_W = 20;

  localparam int unsigned MODE_AUTO = 0;
  localparam int unsigned MODE_HEX  = 1;
  localparam int unsigned MODE_BIN  = 2;

  // Bit0..Bit7 are consecutive so the receiver can step through them by +1
  typedef enum logic [3:0] {
    RX_WAIT_START,
    RX_START_CHECK,
    RX_BIT0, RX_BIT1, RX_BIT2, RX_BIT3, RX_BIT4, RX_BIT5, RX_BIT6, RX_BIT7,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_ID0,
    ST_GET_ID1,
    ST_GET_ID2,
    ST_GET_COMMAND,
    ST_EVAL_COMMAND,
    ST_GET_DATA
  } proto_state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } hex_dec_t;

  function automatic hex_dec_t ascii_to_hex(input logic [7:0] c);
    hex_dec_t r;
    r.valid  = 1'b1;
    r.nibble = 4'h0;
    if (c >= 8'h30 && c <= 8'h39)      r.nibble = 4'(c - 8'h30);
    else if (c >= 8'h41 && c <= 8'h46) r.nibble = 4'(c - 8'h37);
    else if (c >= 8'h61 && c <= 8'h66) r.nibble = 4'(c - 8'h57);
    else                               r.valid  = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/config_uart_v2_if.sv
// Output bus of the configuration UART: packed write word plus status.
interface config_uart_v2_if #(
  parameter int unsigned WORD_BYTES = 4
);
  logic [8*WORD_BYTES-1:0]                   WriteData;
  logic                                      WriteStrobe;
  logic [7:0]                                Command;
  logic                                      ComActive;
  logic                                      FrameError;
  logic [config_uart_pkg::CHECKSUM_W-1:0]    Checksum;
  logic                                      ChecksumOK;

  modport master (
    output WriteData, WriteStrobe, Command, ComActive, FrameError, Checksum, ChecksumOK
  );

  modport slave (
    input WriteData, WriteStrobe, Command, ComActive, FrameError, Checksum, ChecksumOK
  );
endinterface

// File: rtl/uart_rx_core.sv
// UART receiver core: 2-flop Rx synchroniser, bit timer and 8N1 receiver FSM.
// Define CONFIG_UART_PARITY_EN to sample an even-parity bit between Bit7 and Stop.
module uart_rx_core #(
  parameter int unsigned CLK_DIV = 217
) (
  input  logic       CLK,
  input  logic       resetn,
  input  logic       Rx,
  output logic       char_valid,
  output logic [7:0] char_data,
  output logic       frame_err,
  output logic       start_det,
  output logic       in_stop_c
);
  import config_uart_pkg::*;

  localparam int unsigned CNT_W = 12;
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLK_DIV - 1);

  logic [1:0]       sync_q;
  logic             rx_s;
  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             par_bad_q, par_bad_d;
  logic             char_valid_d, frame_err_d, start_det_d;

  assign rx_s      = sync_q[1];
  assign char_data = shift_q;
  assign in_stop_c = (state_q == RX_STOP);

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      sync_q     <= 2'b11;
      state_q    <= RX_WAIT_START;
      cnt_q      <= '0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
      char_valid <= 1'b0;
      frame_err  <= 1'b0;
      start_det  <= 1'b0;
    end else begin
      sync_q     <= {sync_q[0], Rx};
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      par_bad_q  <= par_bad_d;
      char_valid <= char_valid_d;
      frame_err  <= frame_err_d;
      start_det  <= start_det_d;
    end
  end

  // Every sample after the start check is one full bit period after the last
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    par_bad_d    = par_bad_q;
    char_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    start_det_d  = 1'b0;
    case (state_q)
      RX_WAIT_START: begin
        if (!rx_s) begin
          cnt_d       = HALF_LOAD;
          par_bad_d   = 1'b0;
          start_det_d = 1'b1;
          state_d     = RX_START_CHECK;
        end
      end
      RX_START_CHECK: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else if (rx_s)   state_d = RX_WAIT_START;
        else begin
          cnt_d   = BIT_LOAD;
          state_d = RX_BIT0;
        end
      end
      RX_BIT0, RX_BIT1, RX_BIT2, RX_BIT3, RX_BIT4, RX_BIT5, RX_BIT6, RX_BIT7: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = BIT_LOAD;
          if (state_q == RX_BIT7) begin
`ifdef CONFIG_UART_PARITY_EN
            state_d = RX_PARITY;
`else
            state_d = RX_STOP;
`endif
          end else begin
            state_d = rx_state_t'(state_q + 4'd1);
          end
        end
      end
`ifdef CONFIG_UART_PARITY_EN
      RX_PARITY: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else begin
          par_bad_d = ^{shift_q, rx_s};
          cnt_d     = BIT_LOAD;
          state_d   = RX_STOP;
        end
      end
`endif
      RX_STOP: begin
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        else begin
          state_d = RX_WAIT_START;
          if (rx_s && !par_bad_q) char_valid_d = 1'b1;
          else                    frame_err_d  = 1'b1;
        end
      end
      default: state_d = RX_WAIT_START;
    endcase
  end

endmodule

// File: rtl/config_uart_v2.sv
// Configuration UART: sync header + command, then hex or binary data packed into words.
// Define CONFIG_UART_PARITY_EN for 8E1 framing instead of 8N1.
module config_uart_v2 #(
  parameter int unsigned CLK_DIV        = 217,
  parameter int unsigned MODE           = 0,
  parameter int unsigned WORD_BYTES     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16776,
  parameter logic [23:0] SYNC_ID        = 24'h00AAFF,
  parameter logic [19:0] EXP_CHECKSUM   = 20'h4FB00
) (
  input  logic              CLK,
  input  logic              resetn,
  input  logic              Rx,
  config_uart_v2_if.master  bus
);
  import config_uart_pkg::*;

  localparam int unsigned WORD_W = 8 * WORD_BYTES;
  localparam int unsigned PTR_W  = 2;
  localparam int unsigned TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(WORD_BYTES - 1);

  logic       char_valid, frame_err, start_det, in_stop_c;
  logic [7:0] char_data;

  uart_rx_core #(.CLK_DIV(CLK_DIV)) u_rx (
    .CLK        (CLK),
    .resetn     (resetn),
    .Rx         (Rx),
    .char_valid (char_valid),
    .char_data  (char_data),
    .frame_err  (frame_err),
    .start_det  (start_det),
    .in_stop_c  (in_stop_c)
  );

  proto_state_t          state_q, state_d;
  logic [23:0]           id_q, id_d;
  logic [7:0]            cmd_q, cmd_d;
  logic [3:0]            nib_hi_q, nib_hi_d;
  logic                  nib_ptr_q, nib_ptr_d;
  logic                  byte_valid_q, byte_valid_d;
  logic [7:0]            byte_q, byte_d;
  logic [PTR_W-1:0]      byte_ptr_q, byte_ptr_d;
  logic [WORD_W-1:0]     acc_q, acc_d, wdata_q, wdata_d;
  logic                  wstrobe_q, wstrobe_d, fe_q, fe_d, active_q, active_d, cok_q, cok_d;
  logic [CHECKSUM_W-1:0] checksum_q, checksum_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  timeout_c, hex_mode_c;
  hex_dec_t              hex_c;

  assign timeout_c  = (state_q != ST_IDLE) && (tmo_q == TMO_LAST);
  assign hex_mode_c = (MODE == MODE_HEX) || ((MODE == MODE_AUTO) && cmd_q[7]);

  assign bus.WriteData   = wdata_q;
  assign bus.WriteStrobe = wstrobe_q;
  assign bus.Command     = cmd_q;
  assign bus.ComActive   = active_q;
  assign bus.FrameError  = fe_q;
  assign bus.Checksum    = checksum_q;
  assign bus.ChecksumOK  = cok_q;

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      id_q         <= '0;
      cmd_q        <= '0;
      nib_hi_q     <= '0;
      nib_ptr_q    <= 1'b0;
      byte_valid_q <= 1'b0;
      byte_q       <= '0;
      byte_ptr_q   <= '0;
      acc_q        <= '0;
      wdata_q      <= '0;
      wstrobe_q    <= 1'b0;
      fe_q         <= 1'b0;
      active_q     <= 1'b0;
      cok_q        <= 1'b0;
      checksum_q   <= '0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      cmd_q        <= cmd_d;
      nib_hi_q     <= nib_hi_d;
      nib_ptr_q    <= nib_ptr_d;
      byte_valid_q <= byte_valid_d;
      byte_q       <= byte_d;
      byte_ptr_q   <= byte_ptr_d;
      acc_q        <= acc_d;
      wdata_q      <= wdata_d;
      wstrobe_q    <= wstrobe_d;
      fe_q         <= fe_d;
      active_q     <= active_d;
      cok_q        <= cok_d;
      checksum_q   <= checksum_d;
      tmo_q        <= tmo_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    cmd_d        = cmd_q;
    nib_hi_d     = nib_hi_q;
    nib_ptr_d    = nib_ptr_q;
    byte_valid_d = 1'b0;
    byte_d       = byte_q;
    byte_ptr_d   = byte_ptr_q;
    acc_d        = acc_q;
    wdata_d      = wdata_q;
    wstrobe_d    = 1'b0;
    fe_d         = fe_q | frame_err;
    checksum_d   = checksum_q;
    hex_c        = ascii_to_hex(char_data);
    tmo_d        = (state_q == ST_IDLE || in_stop_c) ? '0 : tmo_q + TMO_W'(1);

    // Byte packing: first byte ends up in the MSBs once the word is full
    if (byte_valid_q) begin
      acc_d      = WORD_W'({acc_q, byte_q});
      checksum_d = checksum_q + CHECKSUM_W'(byte_q);
      if (byte_ptr_q == PTR_LAST) begin
        wdata_d    = acc_d;
        wstrobe_d  = 1'b1;
        byte_ptr_d = '0;
      end else begin
        byte_ptr_d = byte_ptr_q + PTR_W'(1);
      end
    end

    case (state_q)
      ST_IDLE: if (start_det) state_d = ST_GET_ID0;
      ST_GET_ID0: if (char_valid) begin
        id_d[23:16] = char_data;
        state_d     = ST_GET_ID1;
      end
      ST_GET_ID1: if (char_valid) begin
        id_d[15:8] = char_data;
        state_d    = ST_GET_ID2;
      end
      ST_GET_ID2: if (char_valid) begin
        id_d[7:0] = char_data;
        fe_d      = 1'b0;
        state_d   = ST_GET_COMMAND;
      end
      ST_GET_COMMAND: begin
        checksum_d = '0;
        byte_ptr_d = '0;
        nib_ptr_d  = 1'b0;
        if (char_valid) begin
          cmd_d   = char_data;
          state_d = ST_EVAL_COMMAND;
        end
      end
      ST_EVAL_COMMAND: begin
        if (id_q == SYNC_ID && (cmd_q[6:0] == 7'h01 || cmd_q[6:0] == 7'h02))
          state_d = ST_GET_DATA;
        else
          state_d = ST_IDLE;
      end
      ST_GET_DATA: if (char_valid) begin
        if (!hex_mode_c) begin
          byte_valid_d = 1'b1;
          byte_d       = char_data;
        end else if (!hex_c.valid) begin
          nib_ptr_d = 1'b0;
        end else if (!nib_ptr_q) begin
          nib_hi_d  = hex_c.nibble;
          nib_ptr_d = 1'b1;
        end else begin
          byte_valid_d = 1'b1;
          byte_d       = {nib_hi_q, hex_c.nibble};
          nib_ptr_d    = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Timeout abandons any partial word
    if (timeout_c) begin
      state_d      = ST_IDLE;
      byte_valid_d = 1'b0;
      byte_ptr_d   = '0;
      nib_ptr_d    = 1'b0;
    end

    active_d = (state_d == ST_GET_DATA);
    cok_d    = (state_d == ST_IDLE) && (checksum_d == EXP_CHECKSUM);
  end

endmodule

// File: tb/tb_config_uart_v2.sv
// Directed bench for config_uart_v2: a 4-byte-word and a 1-byte-word instance share one Rx line.
module tb_config_uart_v2;
  localparam int unsigned DIV = 8;

  logic CLK    = 1'b0;
  logic resetn = 1'b0;
  logic Rx     = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 CLK = ~CLK;

  config_uart_v2_if #(.WORD_BYTES(4)) bus4 ();
  config_uart_v2_if #(.WORD_BYTES(1)) bus1 ();

  config_uart_v2 #(.CLK_DIV(DIV), .MODE(0), .WORD_BYTES(4), .TIMEOUT_CYCLES(200),
                   .SYNC_ID(24'h00AAFF), .EXP_CHECKSUM(20'h00338)) dut4 (
    .CLK(CLK), .resetn(resetn), .Rx(Rx), .bus(bus4));

  config_uart_v2 #(.CLK_DIV(DIV), .MODE(0), .WORD_BYTES(1), .TIMEOUT_CYCLES(200),
                   .SYNC_ID(24'h00AAFF), .EXP_CHECKSUM(20'h0002A)) dut1 (
    .CLK(CLK), .resetn(resetn), .Rx(Rx), .bus(bus1));

  int          strobes4 = 0, strobes1 = 0, active4 = 0;
  logic [31:0] last4 = '0;
  logic [7:0]  last1 = '0;

  always @(negedge CLK) begin
    if (bus4.WriteStrobe) begin strobes4 <= strobes4 + 1; last4 <= bus4.WriteData; end
    if (bus1.WriteStrobe) begin strobes1 <= strobes1 + 1; last1 <= bus1.WriteData; end
    if (bus4.ComActive) active4 <= active4 + 1;
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(negedge CLK); Rx = 1'b0; repeat (DIV) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin Rx = b[i]; repeat (DIV) @(negedge CLK); end
`ifdef CONFIG_UART_PARITY_EN
    Rx = ^b; repeat (DIV) @(negedge CLK);
`endif
    Rx = !bad_stop; repeat (DIV) @(negedge CLK);
    Rx = 1'b1; repeat (bad_stop ? 2 * DIV : 2) @(negedge CLK);
  endtask

  task automatic send_header(input logic [23:0] id, input logic [7:0] cmd);
    send_byte(id[23:16], 1'b0); send_byte(id[15:8], 1'b0);
    send_byte(id[7:0], 1'b0);   send_byte(cmd, 1'b0);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b0);
  endtask

  task automatic wait_idle();
    repeat (260) @(negedge CLK);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (bus4.WriteData !== 32'h0) begin failures++; $display("FAIL reset_wdata got=%0h exp=0", bus4.WriteData); end
    checks++; if (bus4.WriteStrobe !== 1'b0) begin failures++; $display("FAIL reset_strobe got=%0b exp=0", bus4.WriteStrobe); end
    checks++; if (bus4.Command !== 8'h0) begin failures++; $display("FAIL reset_cmd got=%0h exp=0", bus4.Command); end
    checks++; if (bus4.ComActive !== 1'b0) begin failures++; $display("FAIL reset_active got=%0b exp=0", bus4.ComActive); end
    checks++; if (bus4.FrameError !== 1'b0) begin failures++; $display("FAIL reset_fe got=%0b exp=0", bus4.FrameError); end
    checks++; if (bus4.Checksum !== 20'h0) begin failures++; $display("FAIL reset_csum got=%0h exp=0", bus4.Checksum); end
    checks++; if (bus4.ChecksumOK !== 1'b0) begin failures++; $display("FAIL reset_cok got=%0b exp=0", bus4.ChecksumOK); end
    checks++; if (bus1.WriteData !== 8'h0) begin failures++; $display("FAIL reset_wdata1 got=%0h exp=0", bus1.WriteData); end
    resetn = 1'b1;
    repeat (20) @(negedge CLK);
  endtask

  task automatic test_binary();
    int s4, s1;
    s4 = strobes4; s1 = strobes1;
    send_header(24'h00AAFF, 8'h01);
    send_word(32'hDEADBEEF);
    repeat (20) @(negedge CLK);
    checks++; if (strobes4 - s4 !== 1) begin failures++; $display("FAIL bin_strobes got=%0d exp=1", strobes4 - s4); end
    checks++; if (last4 !== 32'hDEADBEEF) begin failures++; $display("FAIL bin_wdata got=%0h exp=deadbeef", last4); end
    checks++; if (bus4.Checksum !== 20'h00338) begin failures++; $display("FAIL bin_csum got=%0h exp=338", bus4.Checksum); end
    checks++; if (bus4.Command !== 8'h01) begin failures++; $display("FAIL bin_cmd got=%0h exp=1", bus4.Command); end
    checks++; if (bus4.ComActive !== 1'b1) begin failures++; $display("FAIL bin_active got=%0b exp=1", bus4.ComActive); end
    checks++; if (bus4.FrameError !== 1'b0) begin failures++; $display("FAIL bin_fe got=%0b exp=0", bus4.FrameError); end
    checks++; if (strobes1 - s1 !== 4) begin failures++; $display("FAIL bin_strobes1 got=%0d exp=4", strobes1 - s1); end
    checks++; if (last1 !== 8'hEF) begin failures++; $display("FAIL bin_wdata1 got=%0h exp=ef", last1); end
    wait_idle();
    checks++; if (bus4.ComActive !== 1'b0) begin failures++; $display("FAIL bin_timeout_active got=%0b exp=0", bus4.ComActive); end
    checks++; if (bus4.ChecksumOK !== 1'b1) begin failures++; $display("FAIL bin_cok got=%0b exp=1", bus4.ChecksumOK); end
  endtask

  task automatic test_glitch();
    int s4;
    s4 = strobes4;
    @(negedge CLK); Rx = 1'b0;
    repeat (3) @(negedge CLK);
    Rx = 1'b1;
    repeat (30) @(negedge CLK);
    checks++; if (bus4.ChecksumOK !== 1'b0) begin failures++; $display("FAIL glitch_left_idle got=%0b exp=0", bus4.ChecksumOK); end
    checks++; if (bus4.ComActive !== 1'b0) begin failures++; $display("FAIL glitch_active got=%0b exp=0", bus4.ComActive); end
    wait_idle();
    checks++; if (bus4.ChecksumOK !== 1'b1) begin failures++; $display("FAIL glitch_back_idle got=%0b exp=1", bus4.ChecksumOK); end
    checks++; if (bus4.Checksum !== 20'h00338) begin failures++; $display("FAIL glitch_csum got=%0h exp=338", bus4.Checksum); end
    checks++; if (strobes4 - s4 !== 0) begin failures++; $display("FAIL glitch_strobes got=%0d exp=0", strobes4 - s4); end
  endtask

  task automatic test_hex();
    int s4, s1;
    s4 = strobes4; s1 = strobes1;
    send_header(24'h00AAFF, 8'h81);
    send_byte(8'h31, 1'b0); send_byte(8'h67, 1'b0);
    send_byte(8'h32, 1'b0); send_byte(8'h41, 1'b0);
    repeat (20) @(negedge CLK);
    checks++; if (strobes1 - s1 !== 1) begin failures++; $display("FAIL hex_strobes1 got=%0d exp=1", strobes1 - s1); end
    checks++; if (last1 !== 8'h2A) begin failures++; $display("FAIL hex_wdata1 got=%0h exp=2a", last1); end
    checks++; if (bus1.Checksum !== 20'h0002A) begin failures++; $display("FAIL hex_csum1 got=%0h exp=2a", bus1.Checksum); end
    checks++; if (bus1.Command !== 8'h81) begin failures++; $display("FAIL hex_cmd1 got=%0h exp=81", bus1.Command); end
    checks++; if (strobes4 - s4 !== 0) begin failures++; $display("FAIL hex_strobes4 got=%0d exp=0", strobes4 - s4); end
    checks++; if (bus4.Checksum !== 20'h0002A) begin failures++; $display("FAIL hex_csum4 got=%0h exp=2a", bus4.Checksum); end
    wait_idle();
    checks++; if (bus1.ChecksumOK !== 1'b1) begin failures++; $display("FAIL hex_cok1 got=%0b exp=1", bus1.ChecksumOK); end
  endtask

  task automatic test_bad_id();
    int s4, s1, a4;
    s4 = strobes4; s1 = strobes1; a4 = active4;
    send_header(24'h00ABFF, 8'h01);
    wait_idle();
    checks++; if (active4 - a4 !== 0) begin failures++; $display("FAIL badid_active got=%0d exp=0", active4 - a4); end
    checks++; if (strobes4 - s4 !== 0) begin failures++; $display("FAIL badid_strobes4 got=%0d exp=0", strobes4 - s4); end
    checks++; if (strobes1 - s1 !== 0) begin failures++; $display("FAIL badid_strobes1 got=%0d exp=0", strobes1 - s1); end
    checks++; if (bus4.Checksum !== 20'h0) begin failures++; $display("FAIL badid_csum got=%0h exp=0", bus4.Checksum); end
    checks++; if (bus4.Command !== 8'h01) begin failures++; $display("FAIL badid_cmd got=%0h exp=1", bus4.Command); end
  endtask

  task automatic test_frame_error();
    int s4, s1;
    s4 = strobes4; s1 = strobes1;
    send_header(24'h00AAFF, 8'h01);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b0); send_byte(8'hEF, 1'b0); send_byte(8'h11, 1'b0);
    repeat (20) @(negedge CLK);
    checks++; if (bus4.FrameError !== 1'b1) begin failures++; $display("FAIL fe_flag got=%0b exp=1", bus4.FrameError); end
    checks++; if (strobes4 - s4 !== 1) begin failures++; $display("FAIL fe_strobes got=%0d exp=1", strobes4 - s4); end
    checks++; if (last4 !== 32'hDEBEEF11) begin failures++; $display("FAIL fe_wdata got=%0h exp=debeef11", last4); end
    checks++; if (bus4.Checksum !== 20'h0029C) begin failures++; $display("FAIL fe_csum got=%0h exp=29c", bus4.Checksum); end
    checks++; if (strobes1 - s1 !== 4) begin failures++; $display("FAIL fe_strobes1 got=%0d exp=4", strobes1 - s1); end
    checks++; if (bus1.FrameError !== 1'b1) begin failures++; $display("FAIL fe_flag1 got=%0b exp=1", bus1.FrameError); end
    wait_idle();
  endtask

  task automatic test_reset_mid_word();
    int s4;
    s4 = strobes4;
    send_header(24'h00AAFF, 8'h02);
    checks++; if (bus4.FrameError !== 1'b0) begin failures++; $display("FAIL mid_fe_cleared got=%0b exp=0", bus4.FrameError); end
    send_byte(8'h11, 1'b0); send_byte(8'h22, 1'b0); send_byte(8'h33, 1'b0);
    @(negedge CLK); resetn = 1'b0;
    repeat (3) @(negedge CLK);
    checks++; if (bus4.WriteData !== 32'h0) begin failures++; $display("FAIL mid_wdata got=%0h exp=0", bus4.WriteData); end
    checks++; if (bus4.Command !== 8'h0) begin failures++; $display("FAIL mid_cmd got=%0h exp=0", bus4.Command); end
    checks++; if (bus4.ComActive !== 1'b0) begin failures++; $display("FAIL mid_active got=%0b exp=0", bus4.ComActive); end
    checks++; if (bus4.Checksum !== 20'h0) begin failures++; $display("FAIL mid_csum got=%0h exp=0", bus4.Checksum); end
    checks++; if (bus1.WriteData !== 8'h0) begin failures++; $display("FAIL mid_wdata1 got=%0h exp=0", bus1.WriteData); end
    checks++; if (strobes4 - s4 !== 0) begin failures++; $display("FAIL mid_no_strobe got=%0d exp=0", strobes4 - s4); end
    resetn = 1'b1;
    repeat (10) @(negedge CLK);
    s4 = strobes4;
    send_header(24'h00AAFF, 8'h02);
    send_word(32'hCAFEBABE);
    repeat (20) @(negedge CLK);
    checks++; if (strobes4 - s4 !== 1) begin failures++; $display("FAIL post_strobes got=%0d exp=1", strobes4 - s4); end
    checks++; if (last4 !== 32'hCAFEBABE) begin failures++; $display("FAIL post_wdata got=%0h exp=cafebabe", last4); end
    checks++; if (bus4.Checksum !== 20'h00340) begin failures++; $display("FAIL post_csum got=%0h exp=340", bus4.Checksum); end
    checks++; if (bus4.Command !== 8'h02) begin failures++; $display("FAIL post_cmd got=%0h exp=2", bus4.Command); end
  endtask

  initial begin
    test_reset();
    test_binary();
    test_glitch();
    test_hex();
    test_bad_id();
    test_frame_error();
    test_reset_mid_word();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
